// File: rtl/vitality_pkg.sv
// rtl/vitality_pkg.sv - shared types for the vitality controller
package vitality_pkg;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_DROWSY = 2'd1,
        ST_ASLEEP = 2'd2,
        ST_WAKING = 2'd3
    } state_e;

    typedef logic [1:0] level_t;

    // Stress level is the top STRESS_LEVEL_W bits of the stress counter.
    localparam int     STRESS_LEVEL_W = 2;
    localparam level_t STRESS_HIGH    = 2'd2;

endpackage

// File: rtl/threshold_classifier.sv
// rtl/threshold_classifier.sv - maps a value onto a 2-bit level via three thresholds
module threshold_classifier
    import vitality_pkg::*;
#(
    parameter int W  = 7,
    parameter int T0 = 16,
    parameter int T1 = 64,
    parameter int T2 = 112
) (
    input  logic [W-1:0] value_i,
    output level_t       level_o
);

    localparam logic [W-1:0] T0_W = W'(T0);
    localparam logic [W-1:0] T1_W = W'(T1);
    localparam logic [W-1:0] T2_W = W'(T2);

    // Lowest band whose upper threshold the value sits below.
    always_comb begin
        level_o = 2'd3;
        if (value_i < T0_W) begin
            level_o = 2'd0;
        end else if (value_i < T1_W) begin
            level_o = 2'd1;
        end else if (value_i < T2_W) begin
            level_o = 2'd2;
        end
    end

endmodule

// File: rtl/vitality_controller.sv
// rtl/vitality_controller.sv - energy/stress counters with a four-state sleep FSM
module vitality_controller
    import vitality_pkg::*;
#(
    parameter int N             = 7,
    parameter int SET_VAL       = 64,
    parameter int LOW_TH        = 16,
    parameter int MID_TH        = 64,
    parameter int HIGH_TH       = 112,
    parameter int INC_STEP      = 2,
    parameter int DEC_STEP      = 1,
    parameter int S             = 5,
    parameter int STRESS_WAKE   = 24,
    parameter int DROWSY_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         stim,
    input  logic         calm,
    input  logic         setval,
    input  logic         force_wake,
    output logic [N-1:0] energy,
    output logic [S-1:0] stress,
    output logic [1:0]   energy_level,
    output logic [1:0]   stress_level,
    output logic [1:0]   state,
    output logic         asleep,
    output logic         fell_asleep,
    output logic         woke_up
);

    generate
        if (!(LOW_TH < MID_TH && MID_TH < HIGH_TH && HIGH_TH < (1 << N))) begin : g_bad_thresholds
            $error("vitality_controller: thresholds must satisfy LOW_TH < MID_TH < HIGH_TH < 2^N");
        end
        if (SET_VAL >= (1 << N) || STRESS_WAKE >= (1 << S) || DROWSY_CYCLES < 1) begin : g_bad_params
            $error("vitality_controller: SET_VAL, STRESS_WAKE or DROWSY_CYCLES out of range");
        end
    endgenerate

    localparam int CW = (DROWSY_CYCLES > 1) ? $clog2(DROWSY_CYCLES) : 1;

    localparam logic [N-1:0]  SET_W       = N'(SET_VAL);
    localparam logic [N:0]    INC_W       = (N+1)'(INC_STEP);
    localparam logic [N:0]    DEC_W       = (N+1)'(DEC_STEP);
    localparam logic [S-1:0]  STRESS_WAKE_W = S'(STRESS_WAKE);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DROWSY_CYCLES - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  energy_q, energy_d;
    logic [S-1:0]  stress_q, stress_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fell_q, fell_d;
    logic          woke_q, woke_d;

    level_t        e_level;
    logic          stress_hi;
    logic [N:0]    e_ext, e_dec, e_sub, e_add;
    logic          s_up, s_down;

    threshold_classifier #(
        .W  (N),
        .T0 (LOW_TH),
        .T1 (MID_TH),
        .T2 (HIGH_TH)
    ) u_energy_cls (
        .value_i (energy_q),
        .level_o (e_level)
    );

    assign stress_level = stress_q[S-1 -: STRESS_LEVEL_W];
    assign stress_hi    = (stress_level >= STRESS_HIGH);

    // Energy arithmetic is done one bit wider so over/underflow shows up before clamping.
    assign e_ext = {1'b0, energy_q};
    assign e_dec = DEC_W + {{N{1'b0}}, stress_hi};
    assign e_sub = e_ext - e_dec;
    assign e_add = e_ext + INC_W;

    // Next energy: load has priority, otherwise drain while awake and recharge while asleep.
    always_comb begin
        energy_d = energy_q;
        if (setval) begin
            energy_d = SET_W;
        end else if (tick) begin
            case (state_q)
                ST_AWAKE, ST_DROWSY: energy_d = (e_dec > e_ext) ? '0 : e_sub[N-1:0];
                ST_ASLEEP:           energy_d = e_add[N] ? '1 : e_add[N-1:0];
                default:             energy_d = energy_q;
            endcase
        end
    end

    assign s_up   = stim & ~calm;
    assign s_down = (calm & ~stim) | (~stim & ~calm & (state_q == ST_ASLEEP));

    // Next stress: step up on stimulus, down on calm or quiet sleep, saturating both ways.
    always_comb begin
        stress_d = stress_q;
        if (tick) begin
            if (s_up && stress_q != '1) begin
                stress_d = stress_q + S'(1);
            end else if (s_down && stress_q != '0) begin
                stress_d = stress_q - S'(1);
            end
        end
    end

    // Sleep FSM next state, drowsy counter and pulse requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fell_d  = 1'b0;
        woke_d  = 1'b0;
        case (state_q)
            ST_AWAKE: begin
                if (tick && e_level == 2'd0 && !stress_hi) begin
                    state_d = ST_DROWSY;
                    cnt_d   = '0;
                end
            end
            ST_DROWSY: begin
                if (tick) begin
                    if (stim || e_level != 2'd0 || stress_hi) begin
                        state_d = ST_AWAKE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_ASLEEP;
                        fell_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_ASLEEP: begin
                if (force_wake || (tick && (e_level == 2'd3 || stress_q >= STRESS_WAKE_W))) begin
                    state_d = ST_WAKING;
                end
            end
            ST_WAKING: begin
                if (tick) begin
                    state_d = ST_AWAKE;
                    woke_d  = 1'b1;
                end
            end
            default: state_d = ST_AWAKE;
        endcase
    end

    // State registers; pulses are registered so each lasts exactly one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_AWAKE;
            energy_q <= SET_W;
            stress_q <= '0;
            cnt_q    <= '0;
            fell_q   <= 1'b0;
            woke_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            energy_q <= energy_d;
            stress_q <= stress_d;
            cnt_q    <= cnt_d;
            fell_q   <= fell_d;
            woke_q   <= woke_d;
        end
    end

    assign energy       = energy_q;
    assign stress       = stress_q;
    assign energy_level = e_level;
    assign state        = state_q;
    assign asleep       = (state_q == ST_ASLEEP);
    assign fell_asleep  = fell_q;
    assign woke_up      = woke_q;

endmodule

// File: tb/tb_vitality_controller.sv
// tb/tb_vitality_controller.sv - self-checking bench for vitality_controller
module tb_vitality_controller;

    localparam int N = 7, SET_VAL = 64, LOW_TH = 16, MID_TH = 64, HIGH_TH = 112;
    localparam int INC_STEP = 2, DEC_STEP = 1, S = 5, STRESS_WAKE = 24, DROWSY_CYCLES = 4;
    localparam int EMAX = (1 << N) - 1;
    localparam int SMAX = (1 << S) - 1;
    localparam int S_QUARTER = 1 << (S - 2);

    logic clk = 1'b0;
    logic rst, tick, stim, calm, setval, force_wake;
    logic [N-1:0] energy;
    logic [S-1:0] stress;
    logic [1:0] energy_level, stress_level, state;
    logic asleep, fell_asleep, woke_up;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain integers, states numbered 0 awake .. 3 waking.
    int m_e, m_s, m_st, m_dozes, m_fell, m_woke;

    vitality_controller #(
        .N(N), .SET_VAL(SET_VAL), .LOW_TH(LOW_TH), .MID_TH(MID_TH), .HIGH_TH(HIGH_TH),
        .INC_STEP(INC_STEP), .DEC_STEP(DEC_STEP), .S(S), .STRESS_WAKE(STRESS_WAKE),
        .DROWSY_CYCLES(DROWSY_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .stim(stim), .calm(calm), .setval(setval),
        .force_wake(force_wake), .energy(energy), .stress(stress), .energy_level(energy_level),
        .stress_level(stress_level), .state(state), .asleep(asleep),
        .fell_asleep(fell_asleep), .woke_up(woke_up)
    );

    always #5 clk = ~clk;

    function automatic int elvl(int e);
        if (e < LOW_TH) return 0;
        if (e < MID_TH) return 1;
        if (e < HIGH_TH) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_e = SET_VAL; m_s = 0; m_st = 0; m_dozes = 0; m_fell = 0; m_woke = 0;
    endtask

    task automatic model_step(input bit t, input bit st, input bit ca, input bit sv, input bit fw);
        int hi, lvl, ne, ns, nst;
        hi  = (m_s / S_QUARTER >= 2) ? 1 : 0;
        lvl = elvl(m_e);
        ne = m_e; ns = m_s; nst = m_st;
        m_fell = 0; m_woke = 0;
        if (sv) ne = SET_VAL;
        else if (t) begin
            if (m_st <= 1) ne = (m_e - DEC_STEP - hi < 0) ? 0 : m_e - DEC_STEP - hi;
            else if (m_st == 2) ne = (m_e + INC_STEP > EMAX) ? EMAX : m_e + INC_STEP;
        end
        if (t) begin
            if (st && !ca) ns = m_s + 1;
            else if (ca && !st) ns = m_s - 1;
            else if (!st && !ca && m_st == 2) ns = m_s - 1;
            if (ns < 0) ns = 0;
            if (ns > SMAX) ns = SMAX;
        end
        if (m_st == 2 && fw) nst = 3;
        else if (t) begin
            if (m_st == 0 && lvl == 0 && !hi) begin
                nst = 1; m_dozes = 0;
            end else if (m_st == 1) begin
                if (st || lvl > 0 || hi) nst = 0;
                else if (m_dozes + 1 == DROWSY_CYCLES) begin
                    nst = 2; m_fell = 1;
                end else m_dozes++;
            end else if (m_st == 2 && (lvl == 3 || m_s >= STRESS_WAKE)) nst = 3;
            else if (m_st == 3) begin
                nst = 0; m_woke = 1;
            end
        end
        m_e = ne; m_s = ns; m_st = nst;
    endtask

    task automatic compare_all();
        chk("energy", int'(energy), m_e);
        chk("stress", int'(stress), m_s);
        chk("energy_level", int'(energy_level), elvl(m_e));
        chk("stress_level", int'(stress_level), m_s / S_QUARTER);
        chk("state", int'(state), m_st);
        chk("asleep", int'(asleep), (m_st == 2) ? 1 : 0);
        chk("fell_asleep", int'(fell_asleep), m_fell);
        chk("woke_up", int'(woke_up), m_woke);
    endtask

    task automatic apply(input bit t, input bit st, input bit ca, input bit sv, input bit fw);
        @(negedge clk);
        tick = t; stim = st; calm = ca; setval = sv; force_wake = fw;
        @(posedge clk);
        model_step(t, st, ca, sv, fw);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values();
        chk("rst_energy", int'(energy), SET_VAL);
        chk("rst_stress", int'(stress), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_energy_level", int'(energy_level), 2);
        chk("rst_fell", int'(fell_asleep), 0);
        chk("rst_woke", int'(woke_up), 0);
    endtask

    // Reset asserted between clock edges; outputs must change before any edge arrives.
    task automatic async_reset();
        @(negedge clk);
        tick = 1'b0; stim = 1'b0; calm = 1'b0; setval = 1'b0; force_wake = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit t, st, ca, sv, fw;
        int e, s, stt, fell, woke;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit reached;
        tbl[0] = '{1, 0, 0, 0, 0, 63, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 63, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 0, 0, 62, 1, 0, 0, 0};
        tbl[3] = '{1, 1, 1, 0, 0, 61, 1, 0, 0, 0};
        tbl[4] = '{1, 0, 1, 0, 0, 60, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 1, 0, 0, 59, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 1, 0, 64, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 0, 1, 0, 64, 1, 0, 0, 0};
        tbl[8] = '{1, 0, 0, 0, 1, 63, 1, 0, 0, 0};

        rst = 1'b1; tick = 1'b0; stim = 1'b0; calm = 1'b0; setval = 1'b0; force_wake = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].t, tbl[i].st, tbl[i].ca, tbl[i].sv, tbl[i].fw);
            chk($sformatf("tbl%0d_energy", i), int'(energy), tbl[i].e);
            chk($sformatf("tbl%0d_stress", i), int'(stress), tbl[i].s);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].stt);
            chk($sformatf("tbl%0d_fell", i), int'(fell_asleep), tbl[i].fell);
            chk($sformatf("tbl%0d_woke", i), int'(woke_up), tbl[i].woke);
        end

        async_reset();

        // Drain to sleep.
        repeat (49) apply(1, 0, 0, 0, 0);
        chk("drain_energy49", int'(energy), 15);
        chk("drain_level49", int'(energy_level), 0);
        chk("drain_state49", int'(state), 0);
        apply(1, 0, 0, 0, 0);
        chk("drain_state50", int'(state), 1);
        repeat (3) apply(1, 0, 0, 0, 0);
        chk("drain_state53", int'(state), 1);
        chk("drain_fell53", int'(fell_asleep), 0);
        apply(1, 0, 0, 0, 0);
        chk("drain_state54", int'(state), 2);
        chk("drain_fell54", int'(fell_asleep), 1);
        chk("drain_energy54", int'(energy), 10);
        apply(0, 0, 0, 0, 0);
        chk("drain_fell_after", int'(fell_asleep), 0);

        // Recovery.
        repeat (51) apply(1, 0, 0, 0, 0);
        chk("recov_energy", int'(energy), 112);
        chk("recov_level", int'(energy_level), 3);
        chk("recov_state_asleep", int'(state), 2);
        apply(1, 0, 0, 0, 0);
        chk("recov_state_waking", int'(state), 3);
        chk("recov_energy_in_waking", int'(energy), 114);
        apply(0, 0, 0, 0, 0);
        chk("recov_waking_waits", int'(state), 3);
        apply(1, 0, 0, 0, 0);
        chk("recov_state_awake", int'(state), 0);
        chk("recov_woke", int'(woke_up), 1);
        chk("recov_energy_held", int'(energy), 114);
        apply(1, 0, 0, 0, 0);
        chk("recov_woke_after", int'(woke_up), 0);

        // Drowsy abort.
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            apply(1, 0, 0, 0, 0);
            if (m_st == 1) reached = 1'b1;
        end
        chk("abort_reached_drowsy", int'(reached), 1);
        repeat (2) apply(1, 0, 0, 0, 0);
        chk("abort_still_drowsy", int'(state), 1);
        apply(1, 1, 0, 0, 0);
        chk("abort_state", int'(state), 0);
        chk("abort_stress", int'(stress), 1);
        chk("abort_fell", int'(fell_asleep), 0);

        // Stress saturation, hold and decay.
        apply(0, 0, 0, 1, 0);
        repeat (40) apply(1, 1, 0, 0, 0);
        chk("sat_stress", int'(stress), 31);
        chk("sat_stress_level", int'(stress_level), 3);
        apply(0, 0, 0, 1, 0);
        apply(1, 1, 1, 0, 0);
        chk("hold_stress", int'(stress), 31);
        chk("hold_energy_dec2", int'(energy), 62);
        repeat (8) apply(1, 0, 1, 0, 0);
        chk("calm_stress", int'(stress), 23);
        chk("calm_energy", int'(energy), 46);
        repeat (8) apply(1, 0, 1, 0, 0);
        chk("calm2_energy", int'(energy), 30);
        apply(1, 1, 0, 0, 0);
        chk("odd_energy", int'(energy), 29);
        repeat (14) apply(1, 1, 1, 0, 0);
        chk("edge_energy_one", int'(energy), 1);
        chk("edge_stress_level", int'(stress_level), 2);
        apply(1, 1, 1, 0, 0);
        chk("edge_energy_zero", int'(energy), 0);
        chk("edge_state_awake", int'(state), 0);

        // Sleep again, then force_wake without tick.
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            apply(1, 0, 1, 0, 0);
            if (m_st == 2) reached = 1'b1;
        end
        chk("fw_reached_asleep", int'(reached), 1);
        chk("fw_asleep_flag", int'(asleep), 1);
        apply(0, 0, 0, 0, 1);
        chk("fw_state_waking", int'(state), 3);
        apply(1, 0, 0, 0, 0);
        chk("fw_woke", int'(woke_up), 1);
        async_reset();

        // force_wake while awake is ignored.
        apply(0, 0, 0, 0, 1);
        chk("fw_awake_state", int'(state), 0);
        chk("fw_awake_energy", int'(energy), 64);
        apply(1, 0, 0, 0, 1);
        chk("fw_awake_tick_state", int'(state), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                apply($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0,
                      $urandom_range(0, 5) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
